// File: rtl/guess_entry.sv
// Keypad front-end for the 1A2B datapath: assembles a 4-digit guess, flags duplicate digits,
// and counts submissions against an attempt limit. All state updates on the falling clock edge.
module guess_entry #(
  parameter int unsigned MAX_ATTEMPTS = 10,
  parameter int unsigned ATT_W        = 4
) (
  input  logic             clka,
  input  logic             reset,
  input  logic             new_game,
  input  logic             enable,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [3:0]       ans0,
  output logic [3:0]       ans1,
  output logic [3:0]       ans2,
  output logic [3:0]       ans3,
  output logic [2:0]       digit_count,
  output logic             dup_error,
  output logic             submit,
  output logic             key_reject,
  output logic [ATT_W-1:0] attempts,
  output logic             locked
);

  typedef enum logic [1:0] {StIdle, StEntry, StDone, StLock} state_e;

  localparam logic [3:0]       Empty  = 4'hF;
  localparam logic [3:0]       KeyBs  = 4'd10;
  localparam logic [3:0]       KeyClr = 4'd11;
  localparam logic [3:0]       KeyEnt = 4'd12;
  localparam logic [ATT_W-1:0] AttOne = 1;
  localparam logic [ATT_W-1:0] MaxAtt = ATT_W'(MAX_ATTEMPTS);

  state_e           state_q, state_d;
  logic [3:0]       slot_q [4];
  logic [3:0]       slot_d [4];
  logic [2:0]       count_q, count_d;
  logic             dup_q, dup_d;
  logic             submit_q, submit_d;
  logic             reject_q, reject_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic [ATT_W-1:0] att_inc;
  logic             locked_q, locked_d;
  logic             is_digit;
  logic [1:0]       last_idx;

  assign is_digit = (key_code <= 4'd9);
  // Wraps correctly for count 1..4 -> index 0..3.
  assign last_idx = count_q[1:0] - 2'd1;
  assign att_inc  = att_q + AttOne;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    count_d  = count_q;
    att_d    = att_q;
    locked_d = locked_q;
    submit_d = 1'b0;
    reject_d = 1'b0;

    if (new_game) begin
      slot_d   = '{default: Empty};
      count_d  = 3'd0;
      att_d    = '0;
      locked_d = 1'b0;
      state_d  = enable ? StEntry : StIdle;
    end else if (!enable) begin
      reject_d = key_valid;
      // Lock survives enable dropping; only new_game or reset release it.
      if (state_q != StLock) state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StEntry;
          reject_d = key_valid;
        end
        StLock: reject_d = key_valid;
        StEntry: begin
          if (key_valid) begin
            if (is_digit) begin
              if (count_q < 3'd4) begin
                slot_d[count_q[1:0]] = key_code;
                count_d              = count_q + 3'd1;
              end else begin
                reject_d = 1'b1;
              end
            end else if (key_code == KeyBs) begin
              if (count_q != 3'd0) begin
                slot_d[last_idx] = Empty;
                count_d          = count_q - 3'd1;
              end else begin
                reject_d = 1'b1;
              end
            end else if (key_code == KeyClr) begin
              slot_d  = '{default: Empty};
              count_d = 3'd0;
            end else if (key_code == KeyEnt) begin
              if (count_q == 3'd4 && !dup_q) begin
                submit_d = 1'b1;
                att_d    = att_inc;
                if (att_inc == MaxAtt) begin
                  state_d  = StLock;
                  locked_d = 1'b1;
                end else begin
                  state_d = StDone;
                end
              end else begin
                reject_d = 1'b1;
              end
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        StDone: begin
          if (key_valid) begin
            if (is_digit) begin
              slot_d    = '{default: Empty};
              slot_d[0] = key_code;
              count_d   = 3'd1;
              state_d   = StEntry;
            end else if (key_code == KeyClr) begin
              slot_d  = '{default: Empty};
              count_d = 3'd0;
              state_d = StEntry;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
      endcase
    end

    dup_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (3'(j) < count_d && slot_d[i] != Empty && slot_d[i] == slot_d[j]) dup_d = 1'b1;
      end
    end
  end

  always_ff @(negedge clka) begin
    if (reset) begin
      state_q  <= StIdle;
      slot_q   <= '{default: Empty};
      count_q  <= 3'd0;
      dup_q    <= 1'b0;
      submit_q <= 1'b0;
      reject_q <= 1'b0;
      att_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      count_q  <= count_d;
      dup_q    <= dup_d;
      submit_q <= submit_d;
      reject_q <= reject_d;
      att_q    <= att_d;
      locked_q <= locked_d;
    end
  end

  assign ans0        = slot_q[0];
  assign ans1        = slot_q[1];
  assign ans2        = slot_q[2];
  assign ans3        = slot_q[3];
  assign digit_count = count_q;
  assign dup_error   = dup_q;
  assign submit      = submit_q;
  assign key_reject  = reject_q;
  assign attempts    = att_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: queue-based guess model checked every cycle, directed scenarios with
// literal expectations, then randomized key streams.
module tb_guess_entry;

  localparam int MAXA = 2;

  logic       clka = 1'b0;
  logic       r_rst, r_ng, r_en, r_kv;
  logic [3:0] r_kc;
  logic [3:0] ans0, ans1, ans2, ans3;
  logic [2:0] digit_count;
  logic       dup_error, submit, key_reject, locked;
  logic [3:0] attempts;

  guess_entry #(.MAX_ATTEMPTS(MAXA), .ATT_W(4)) dut (
    .clka       (clka),
    .reset      (r_rst),
    .new_game   (r_ng),
    .enable     (r_en),
    .key_valid  (r_kv),
    .key_code   (r_kc),
    .ans0       (ans0),
    .ans1       (ans1),
    .ans2       (ans2),
    .ans3       (ans3),
    .digit_count(digit_count),
    .dup_error  (dup_error),
    .submit     (submit),
    .key_reject (key_reject),
    .attempts   (attempts),
    .locked     (locked)
  );

  always #5 clka = ~clka;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  // Model: guess held as a queue of digits plus a few game flags.
  int md[$];
  bit m_active, m_done, m_lock, m_submit, m_reject, m_dup;
  int m_att;

  function automatic bit dup_of();
    for (int i = 0; i < md.size(); i++)
      for (int j = i + 1; j < md.size(); j++)
        if (md[i] == md[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_ans(int i);
    return (i < md.size()) ? md[i] : 15;
  endfunction

  task automatic model_step();
    m_submit = 0;
    m_reject = 0;
    if (r_rst) begin
      md.delete();
      m_active = 0; m_done = 0; m_lock = 0; m_att = 0;
    end else if (r_ng) begin
      md.delete();
      m_att = 0; m_lock = 0; m_done = 0; m_active = r_en;
    end else if (!r_en) begin
      m_reject = r_kv;
      if (!m_lock) begin m_active = 0; m_done = 0; end
    end else if (m_lock) begin
      m_reject = r_kv;
    end else if (!m_active) begin
      m_active = 1;
      m_reject = r_kv;
    end else if (r_kv) begin
      if (m_done) begin
        if (r_kc <= 9) begin md.delete(); md.push_back(int'(r_kc)); m_done = 0; end
        else if (r_kc == 11) begin md.delete(); m_done = 0; end
        else m_reject = 1;
      end else begin
        if (r_kc <= 9) begin
          if (md.size() < 4) md.push_back(int'(r_kc));
          else m_reject = 1;
        end else if (r_kc == 10) begin
          if (md.size() > 0) void'(md.pop_back());
          else m_reject = 1;
        end else if (r_kc == 11) begin
          md.delete();
        end else if (r_kc == 12) begin
          if (md.size() == 4 && !dup_of()) begin
            m_submit = 1;
            m_att++;
            if (m_att == MAXA) m_lock = 1;
            else m_done = 1;
          end else m_reject = 1;
        end else m_reject = 1;
      end
    end
    m_dup = dup_of();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clka) begin
    if (chk_en) begin
      vectors++;
      chk("ans0", 32'(ans0), 32'(exp_ans(0)));
      chk("ans1", 32'(ans1), 32'(exp_ans(1)));
      chk("ans2", 32'(ans2), 32'(exp_ans(2)));
      chk("ans3", 32'(ans3), 32'(exp_ans(3)));
      chk("digit_count", 32'(digit_count), 32'(md.size()));
      chk("dup_error", 32'(dup_error), 32'(m_dup));
      chk("submit", 32'(submit), 32'(m_submit));
      chk("key_reject", 32'(key_reject), 32'(m_reject));
      chk("attempts", 32'(attempts), 32'(m_att));
      chk("locked", 32'(locked), 32'(m_lock));
    end
  end

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    chk({"lit_", name}, act, exp);
  endtask

  task automatic cycle(bit rst, bit ng, bit en, bit kv, logic [3:0] kc);
    r_rst = rst; r_ng = ng; r_en = en; r_kv = kv; r_kc = kc;
    @(negedge clka);
    model_step();
    chk_en = 1;
    @(posedge clka);
    #1;
  endtask

  task automatic key(logic [3:0] kc);
    cycle(0, 0, 1, 1, kc);
  endtask

  task automatic idle();
    cycle(0, 0, 1, 0, 4'd0);
  endtask

  initial begin
    r_rst = 1; r_ng = 0; r_en = 0; r_kv = 0; r_kc = 0;
    @(posedge clka);
    #1;
    cycle(1, 0, 0, 0, 4'd0);
    lit("rst_ans0", 32'(ans0), 32'hF);
    lit("rst_count", 32'(digit_count), 0);
    lit("rst_att", 32'(attempts), 0);
    lit("rst_locked", 32'(locked), 0);

    idle();  // IDLE -> ENTRY
    key(1); key(2); key(3); key(4);
    lit("g1", {ans0, ans1, ans2, ans3}, 32'h1234);
    lit("g1_count", 32'(digit_count), 4);
    key(12);
    lit("g1_submit", 32'(submit), 1);
    lit("g1_att", 32'(attempts), 1);
    idle();
    lit("g1_submit_off", 32'(submit), 0);

    key(12);
    lit("done_enter_rej", 32'(key_reject), 1);
    lit("done_enter_att", 32'(attempts), 1);
    key(9);
    lit("done_digit", {ans0, ans1, ans2, ans3}, 32'h9FFF);
    lit("done_digit_cnt", 32'(digit_count), 1);

    key(11); key(5); key(5);
    lit("dup", 32'(dup_error), 1);
    key(6); key(7); key(12);
    lit("dup_enter_rej", 32'(key_reject), 1);
    lit("dup_enter_sub", 32'(submit), 0);
    lit("dup_enter_att", 32'(attempts), 1);
    key(10); key(10); key(10);
    key(6); key(7); key(8);
    lit("fixed", {ans0, ans1, ans2, ans3}, 32'h5678);
    lit("fixed_dup", 32'(dup_error), 0);
    key(1);
    lit("fifth_rej", 32'(key_reject), 1);
    lit("fifth_ans3", 32'(ans3), 8);
    key(14);
    lit("illegal_rej", 32'(key_reject), 1);
    key(12);
    lit("last_submit", 32'(submit), 1);
    lit("locked", 32'(locked), 1);
    lit("att_max", 32'(attempts), MAXA);
    key(3);
    lit("lock_rej", 32'(key_reject), 1);
    cycle(0, 1, 1, 0, 4'd0);
    lit("ng_att", 32'(attempts), 0);
    lit("ng_locked", 32'(locked), 0);
    key(10);
    lit("bs_empty_rej", 32'(key_reject), 1);
    key(1); key(2); key(3);
    cycle(1, 0, 1, 1, 4'd12);
    lit("rst_mid_cnt", 32'(digit_count), 0);
    lit("rst_mid_sub", 32'(submit), 0);
    lit("rst_mid_ans0", 32'(ans0), 32'hF);
    idle();
    lit("rst_mid_sub2", 32'(submit), 0);
    cycle(0, 0, 0, 1, 4'd4);
    lit("dis_rej", 32'(key_reject), 1);

    for (int n = 0; n < 4000; n++) begin
      bit rst, ng, en, kv;
      logic [3:0] kc;
      int sel;
      rst = ($urandom_range(0, 299) == 0);
      ng  = ($urandom_range(0, 119) == 0);
      en  = ($urandom_range(0, 29) != 0);
      kv  = ($urandom_range(0, 9) < 6);
      sel = $urandom_range(0, 19);
      if (sel < 12)      kc = 4'($urandom_range(0, 9));
      else if (sel < 14) kc = 4'd10;
      else if (sel < 15) kc = 4'd11;
      else if (sel < 19) kc = 4'd12;
      else               kc = 4'($urandom_range(13, 15));
      cycle(rst, ng, en, kv, kc);
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
